// File: rtl/phy_pkg.sv
// phy_pkg: shared constants and receiver state encoding for the serial lane.
package phy_pkg;
    localparam logic [7:0] COMMA      = 8'hBC;
    localparam logic [2:0] LOCK_COUNT = 3'd4;
    typedef enum logic [1:0] {SEARCH = 2'd0, SYNC = 2'd1, ACTIVE = 2'd2} rx_state_t;
endpackage

// File: rtl/rx_shift_reg.sv
// rx_shift_reg: serial shift register plus free-running bit counter marking byte boundaries.
// The oldest bit of the 8-bit window is never read, so only the seven newest bits are stored.
module rx_shift_reg (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       data_i,
    input  logic       clr_i,
    output logic [7:0] cand_o,
    output logic       boundary_o
);
    logic [6:0] shift_q;
    logic [2:0] cnt_q;

    assign cand_o     = {shift_q, data_i};
    assign boundary_o = cnt_q == 3'd7;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            shift_q <= '0;
            cnt_q   <= '0;
        end else begin
            shift_q <= cand_o[6:0];
            cnt_q   <= clr_i ? 3'd0 : cnt_q + 3'd1;
        end
    end
endmodule

// File: rtl/serial_to_parallel_rx.sv
// serial_to_parallel_rx: comma-aligned deserializer; locks after four aligned commas,
// then emits each non-comma byte with a one-cycle valid pulse on the edge its LSB arrives.
module serial_to_parallel_rx
    import phy_pkg::*;
(
    input  logic       clk_8f,
    input  logic       reset_L,
    input  logic       data_in,
    output logic [7:0] data_out,
    output logic       valid_out,
    output logic       active
);
    rx_state_t  state_q, state_d;
    logic [2:0] bc_q, bc_d;
    logic [7:0] data_q, data_d;
    logic       valid_q, valid_d;
    logic [7:0] cand;
    logic       bnd, is_comma;

    assign is_comma = cand == COMMA;

    // A comma found while hunting restarts the counter so the next boundary is 8 edges out.
    rx_shift_reg u_shift (
        .clk_i      (clk_8f),
        .rst_ni     (reset_L),
        .data_i     (data_in),
        .clr_i      (state_q == SEARCH && is_comma),
        .cand_o     (cand),
        .boundary_o (bnd)
    );

    always_comb begin
        state_d = state_q;
        bc_d    = bc_q;
        data_d  = data_q;
        valid_d = 1'b0;
        case (state_q)
            SEARCH: if (is_comma) begin
                state_d = SYNC;
                bc_d    = 3'd1;
            end
            SYNC: if (bnd) begin
                if (is_comma) begin
                    bc_d    = bc_q + 3'd1;
                    state_d = (bc_q + 3'd1 == LOCK_COUNT) ? ACTIVE : SYNC;
                end else begin
                    state_d = SEARCH;
                    bc_d    = 3'd0;
                end
            end
            ACTIVE: if (bnd && !is_comma) begin
                valid_d = 1'b1;
                data_d  = cand;
            end
            default: state_d = SEARCH;
        endcase
    end

    always_ff @(posedge clk_8f or negedge reset_L) begin
        if (!reset_L) begin
            state_q <= SEARCH;
            bc_q    <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            bc_q    <= bc_d;
            data_q  <= data_d;
            valid_q <= valid_d;
        end
    end

    assign data_out  = data_q;
    assign valid_out = valid_q;
    assign active    = state_q == ACTIVE;
endmodule

// File: tb/tb_serial_to_parallel_rx.sv
// tb_serial_to_parallel_rx: directed and randomized checks against a bit-stream reference model.
module tb_serial_to_parallel_rx;
    localparam logic [7:0] C = 8'hBC;

    logic       clk_8f = 1'b0;
    logic       reset_L = 1'b0;
    logic       data_in = 1'b0;
    logic [7:0] data_out;
    logic       valid_out, active;

    int n_checks = 0;
    int n_fail   = 0;

    serial_to_parallel_rx dut (
        .clk_8f    (clk_8f),
        .reset_L   (reset_L),
        .data_in   (data_in),
        .data_out  (data_out),
        .valid_out (valid_out),
        .active    (active)
    );

    always #5 clk_8f = ~clk_8f;

    // Reference model: window of the last 8 bits, byte phase measured from the edge the first comma completed.
    int         m_n, m_anchor, m_commas;
    bit         m_search, m_active, m_valid;
    logic [7:0] m_win, m_data;

    task automatic model_reset();
        m_n = 0; m_anchor = 0; m_commas = 0;
        m_search = 1; m_active = 0; m_valid = 0;
        m_win = 8'h00; m_data = 8'h00;
    endtask

    task automatic model_step(input bit b);
        bit bnd;
        m_n++;
        m_win   = {m_win[6:0], b};
        bnd     = !m_search && ((m_n - m_anchor) % 8 == 0);
        m_valid = 0;
        if (m_active) begin
            if (bnd && m_win != C) begin
                m_valid = 1;
                m_data  = m_win;
            end
        end else if (m_search) begin
            if (m_win == C) begin
                m_search = 0;
                m_anchor = m_n;
                m_commas = 1;
            end
        end else if (bnd) begin
            if (m_win == C) begin
                m_commas++;
                m_active = (m_commas == 4);
            end else m_search = 1;
        end
    endtask

    task automatic send_bit(input bit b);
        @(negedge clk_8f);
        data_in = b;
        @(posedge clk_8f);
        #1;
        model_step(b);
    endtask

    task automatic do_reset();
        @(negedge clk_8f);
        reset_L = 1'b0;
        data_in = 1'b0;
        @(posedge clk_8f);
        #1;
        reset_L = 1'b1;
        model_reset();
    endtask

    task automatic test_reset();
        model_reset();
        for (int i = 0; i < 4; i++) begin
            @(negedge clk_8f);
            data_in = ~data_in;
            @(posedge clk_8f);
            #1;
            n_checks++;
            if ({active, valid_out, data_out} !== 10'h000) begin
                n_fail++;
                $display("FAIL reset edge %0d: got a=%b v=%b d=%h want a=0 v=0 d=00", i, active, valid_out, data_out);
            end
        end
        reset_L = 1'b1;
    endtask

    task automatic test_lock();
        logic [31:0] cs;
        cs = {C, C, C, C};
        for (int i = 0; i < 3; i++) send_bit(1'($urandom_range(0, 1)));
        for (int k = 0; k < 32; k++) begin
            send_bit(cs[31-k]);
            n_checks++;
            if (active !== (k == 31) || valid_out !== 1'b0 || {active, valid_out, data_out} !== {m_active, m_valid, m_data}) begin
                n_fail++;
                $display("FAIL lock bit %0d: got a=%b v=%b d=%h want a=%b v=0 d=%h", k, active, valid_out, data_out, k == 31, m_data);
            end
        end
    endtask

    task automatic test_data();
        logic [7:0] bytes [4] = '{8'hEC, 8'hAC, 8'hBC, 8'hAA};
        logic [7:0] exp_d [4] = '{8'hEC, 8'hAC, 8'hAC, 8'hAA};
        bit         exp_v [4] = '{1, 1, 0, 1};
        for (int j = 0; j < 4; j++) begin
            for (int i = 7; i >= 0; i--) begin
                send_bit(bytes[j][i]);
                n_checks++;
                if ({active, valid_out, data_out} !== {m_active, m_valid, m_data}) begin
                    n_fail++;
                    $display("FAIL data_model byte %0d bit %0d: got a=%b v=%b d=%h want a=%b v=%b d=%h", j, i, active, valid_out, data_out, m_active, m_valid, m_data);
                end
            end
            n_checks++;
            if (valid_out !== exp_v[j] || data_out !== exp_d[j]) begin
                n_fail++;
                $display("FAIL data byte %0d: got v=%b d=%h want v=%b d=%h", j, valid_out, data_out, exp_v[j], exp_d[j]);
            end
        end
    endtask

    task automatic test_failed_lock();
        logic [7:0] bytes [7] = '{C, C, 8'h55, C, C, C, C};
        do_reset();
        for (int j = 0; j < 7; j++) begin
            for (int i = 7; i >= 0; i--) begin
                send_bit(bytes[j][i]);
                n_checks++;
                if (active !== (j == 6 && i == 0) || valid_out !== 1'b0) begin
                    n_fail++;
                    $display("FAIL failed_lock byte %0d bit %0d: got a=%b v=%b want a=%b v=0", j, i, active, valid_out, j == 6 && i == 0);
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [7:0] b;
        b = 8'h5A;
        for (int i = 7; i >= 0; i--) send_bit(b[i]);
        n_checks++;
        if (active !== 1'b1 || valid_out !== 1'b1 || data_out !== 8'h5A) begin
            n_fail++;
            $display("FAIL pre_reset: got a=%b v=%b d=%h want a=1 v=1 d=5a", active, valid_out, data_out);
        end
        b = 8'h99;
        for (int i = 7; i >= 5; i--) send_bit(b[i]);
        #2;
        reset_L = 1'b0;
        #1;
        n_checks++;
        if ({active, valid_out, data_out} !== 10'h000) begin
            n_fail++;
            $display("FAIL async_reset: got a=%b v=%b d=%h want a=0 v=0 d=00", active, valid_out, data_out);
        end
        @(posedge clk_8f);
        #1;
        reset_L = 1'b1;
        model_reset();
        for (int j = 0; j < 4; j++)
            for (int i = 7; i >= 0; i--) send_bit(C[i]);
        b = 8'h11;
        for (int i = 7; i >= 0; i--) send_bit(b[i]);
        n_checks++;
        if (active !== 1'b1 || valid_out !== 1'b1 || data_out !== 8'h11) begin
            n_fail++;
            $display("FAIL relock: got a=%b v=%b d=%h want a=1 v=1 d=11", active, valid_out, data_out);
        end
    endtask

    task automatic test_misalign();
        logic [4:0] junk;
        logic [7:0] b;
        junk = 5'b01101;
        do_reset();
        for (int i = 4; i >= 0; i--) send_bit(junk[i]);
        for (int j = 0; j < 4; j++)
            for (int i = 7; i >= 0; i--) send_bit(C[i]);
        n_checks++;
        if (active !== 1'b1 || valid_out !== 1'b0) begin
            n_fail++;
            $display("FAIL misalign_lock: got a=%b v=%b want a=1 v=0", active, valid_out);
        end
        b = 8'h66;
        for (int i = 7; i >= 0; i--) send_bit(b[i]);
        n_checks++;
        if (valid_out !== 1'b1 || data_out !== 8'h66) begin
            n_fail++;
            $display("FAIL misalign_data: got v=%b d=%h want v=1 d=66", valid_out, data_out);
        end
    endtask

    task automatic test_random();
        logic [7:0] b;
        int         nj;
        do_reset();
        nj = $urandom_range(0, 7);
        for (int i = 0; i < nj; i++) send_bit(1'($urandom_range(0, 1)));
        for (int j = 0; j < 28; j++) begin
            b = (j < 4 || $urandom_range(0, 3) == 0) ? C : 8'($urandom);
            for (int i = 7; i >= 0; i--) begin
                send_bit(b[i]);
                n_checks++;
                if ({active, valid_out, data_out} !== {m_active, m_valid, m_data}) begin
                    n_fail++;
                    $display("FAIL random byte %0d bit %0d: got a=%b v=%b d=%h want a=%b v=%b d=%h", j, i, active, valid_out, data_out, m_active, m_valid, m_data);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_lock();
        test_data();
        test_failed_lock();
        test_reset_mid();
        test_misalign();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
